// File: rtl/fpu_pkg.sv
// Shared single-precision constants, field layout and field-extract helpers for the FPU units.
package fpu_pkg;

   localparam int unsigned FP_EXP_BIAS = 127;
   localparam int unsigned FP_EXP_W    = 8;
   localparam int unsigned FP_MANT_W   = 23;

   localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;

   typedef struct packed {
      logic                 sign;
      logic [FP_EXP_W-1:0]  exp;
      logic [FP_MANT_W-1:0] mant;
   } fp32_t;

   function automatic logic fp_sign(input logic [31:0] f);
      return f[31];
   endfunction

   function automatic logic [FP_EXP_W-1:0] fp_exp(input logic [31:0] f);
      return f[30:23];
   endfunction

   function automatic logic [FP_MANT_W-1:0] fp_mant(input logic [31:0] f);
      return f[22:0];
   endfunction

endpackage

// File: rtl/lzc32.sv
// Combinational 32-bit leading-zero counter; reports 32 for an all-zero input.
module lzc32 (
   input  logic [31:0] data,
   output logic [5:0]  count
);

   // Scan from the LSB so the highest set bit is the last to win.
   always_comb begin
      count = 6'd32;
      for (int i = 0; i < 32; i++) begin
         if (data[i]) count = 6'(31 - i);
      end
   end

endmodule

// File: rtl/itof_pipe.sv
// Three-stage integer to IEEE-754 single converter (round-to-nearest-even), valid/ready on
// both sides with per-stage ready chaining and no skid buffer.
module itof_pipe
   import fpu_pkg::*;
#(
   parameter bit SIGNED_IN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data
);

   // Exponent of a value whose MSB sits at bit 31 of the magnitude.
   localparam logic [FP_EXP_W-1:0] EXP_TOP = FP_EXP_W'(FP_EXP_BIAS + 31);

   logic s1_valid, s2_valid, s3_valid;
   logic ready1, ready2, ready3;

   logic        s1_sign;
   logic [31:0] s1_mag;

   logic                s2_sign;
   logic                s2_zero;
   logic [30:0]         s2_norm;
   logic [FP_EXP_W-1:0] s2_exp;

   logic        sign_d;
   logic [31:0] mag_d;
   logic [5:0]  lz;
   logic [31:0] norm_full;

   logic [FP_MANT_W-1:0] mant;
   logic                 guard, sticky, round_up;
   logic [30:0]          mag_rnd;
   fp32_t                res_d;

   assign ready3    = ~s3_valid | out_ready;
   assign ready2    = ~s2_valid | ready3;
   assign ready1    = ~s1_valid | ready2;
   assign in_ready  = ready1;
   assign out_valid = s3_valid;

   // S1: sign/magnitude split; 32'h80000000 negates to itself, which is the right magnitude.
   always_comb begin
      sign_d = SIGNED_IN ? in_data[31] : 1'b0;
      mag_d  = sign_d ? (~in_data + 32'd1) : in_data;
   end

   lzc32 u_lzc (
      .data  (s1_mag),
      .count (lz)
   );

   assign norm_full = s1_mag << lz;

   // S3: round-to-nearest-even; a mantissa carry ripples straight into the exponent field.
   always_comb begin
      mant     = s2_norm[30:8];
      guard    = s2_norm[7];
      sticky   = |s2_norm[6:0];
      round_up = guard & (sticky | mant[0]);
      mag_rnd  = {s2_exp, mant} + 31'(round_up);
      res_d    = s2_zero ? fp32_t'(FP_POS_ZERO)
                         : '{sign: s2_sign, exp: mag_rnd[30:23], mant: mag_rnd[22:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s2_valid <= 1'b0;
         s3_valid <= 1'b0;
         out_data <= FP_POS_ZERO;
      end else begin
         if (ready1) s1_valid <= in_valid;
         if (ready2) s2_valid <= s1_valid;
         if (ready3) s3_valid <= s2_valid;
         if (ready3 && s2_valid) out_data <= res_d;
      end
   end

   // Payload registers carry no reset; their contents only matter while the stage is valid.
   always_ff @(posedge clk) begin
      if (ready1) begin
         s1_sign <= sign_d;
         s1_mag  <= mag_d;
      end
      if (ready2) begin
         s2_sign <= s1_sign;
         s2_norm <= norm_full[30:0];
         s2_exp  <= EXP_TOP - {2'b00, lz};
         // After normalisation bit 31 is set for every non-zero magnitude.
         s2_zero <= ~norm_full[31];
      end
   end

endmodule
